rf_wb_serializer: RTL and testbench
===================================

Name: rf_wb_serializer

Overview:
Writeback front end for regfile_multi_bank. It accepts one full-warp result per handshake from the execution pipeline. Vector results are serialized onto the register file's one-lane-per-cycle vector write port, visiting only active lanes. Scalar results go onto the scalar write port. A completion pulse tells the scoreboard when the destination register is fully written.

Parameters:
NUM_WARPS, 32, warps per SM; warp index is 6 bits.
NUM_LANES, 32, lanes per warp.
VREG_COUNT, 128, vector registers per lane.
SREG_COUNT, 32, scalar registers per warp.
W, 32, data width.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  result offered
in_ready  out  1  block can accept a result
in_is_scalar  in  1  1 = scalar result, 0 = vector result
in_warp  in  6  destination warp
in_addr  in  $clog2(VREG_COUNT)  destination register; scalar uses low $clog2(SREG_COUNT) bits
in_mask  in  NUM_LANES  active-lane mask (ignored for scalar)
in_data  in  NUM_LANES*W  lane data; lane i at [i*W +: W]; scalar uses lane 0
s_wen, s_wwarp[6], s_waddr[$clog2(SREG_COUNT)], s_wdata[W]  out  scalar write port
v_wen, v_wwarp[6], v_wlane[$clog2(NUM_LANES)], v_waddr[$clog2(VREG_COUNT)], v_wdata[W]  out  vector write port
busy  out  1  a result is held
done_valid  out  1  one-cycle completion pulse
done_warp  out  6  warp of completed result
done_addr  out  $clog2(VREG_COUNT)  register of completed result
perf_lanes  out  32  lane writes counter (see Optional Feature)
perf_results  out  32  retired results counter

Behaviour:
- States: IDLE, SCALAR, DRAIN.
- Reset: state goes to IDLE and the held mask clears. All outputs reset to 0: every wen, address and data output, busy, done_*, and the perf counters.
- in_ready = (state == IDLE). An accept happens when in_valid & in_ready. There is no back-to-back overlap: after an accept, in_ready stays 0 until the cycle after the last write.
- On accept, the block registers warp, addr, mask, data and the scalar flag.
  - Scalar: next state is SCALAR.
  - Vector with mask != 0: next state is DRAIN.
  - Vector with mask == 0: next state is SCALAR-style single cycle with no write; done pulses only.
- SCALAR (one cycle):
  - s_wen = 1 and s_waddr = addr[$clog2(SREG_COUNT)-1:0], with s_wdata = lane-0 data.
  - done_valid = 1.
  - Next state is IDLE.
- DRAIN, each cycle:
  - lane = lowest set bit of the remaining mask.
  - Drive v_wen = 1, v_wlane = lane, v_wdata = data[lane], v_waddr = addr, v_wwarp = warp.
  - Clear that mask bit.
  - If the remaining mask after clearing is 0, assert done_valid in the same cycle and go to IDLE.
- Timing:
  - First write occurs the cycle after accept.
  - A vector result with k active lanes occupies exactly k cycles.
  - Lanes are written in ascending order.
- Write outputs are registered, and all write and done outputs are 0 when not asserted.
- s_wen and v_wen are never high in the same cycle.
- busy = (state != IDLE).
- done_warp and done_addr are valid only while done_valid = 1, and are 0 otherwise.
- Reset mid-DRAIN: the remaining lanes are dropped and no done pulse is issued.
- in_warp >= NUM_WARPS is passed through unchecked.

Optional Feature:
RF_WB_PERF_EN
- Defined:
  - perf_lanes increments by 1 per v_wen cycle and by 1 per s_wen cycle.
  - perf_results increments per done_valid.
  - Both wrap at 2^32.
  - Both clear on rst.
- Undefined: both outputs are tied to 0 and no counter flops are inferred.

Decomposition:
- Package rf_wb_pkg holds: the wb_state_t enum {IDLE, SCALAR, DRAIN}; localparams for lane, vector-address and scalar-address widths derived from the defaults; and WARP_W = 6.
- Sub-module rf_wb_lane_pick: a combinational lowest-set-bit priority encoder with NUM_LANES inputs. Its outputs are the lane index, an any-set flag, and the mask with that bit cleared.

Test Plan:
- Vector, mask 0x0000_0001, warp 3, addr 0x10 -> one v_wen with lane 0; done_valid in the same cycle; in_ready returns 1 the next cycle.
- Vector, mask 0x8000_0005, warp 7, addr 0x7F -> v_wen over 3 consecutive cycles with lanes 0, 2, 31 and the matching data words; done_valid on the lane-31 cycle.
- Scalar, warp 31, addr 0x25, lane-0 data 0xDEADBEEF -> one s_wen with s_waddr 0x05, s_wdata 0xDEADBEEF; no v_wen; done_valid in the same cycle.
- Vector with mask 0 -> no wen at all; done_valid one cycle after accept.
- Mask 0xFFFF_FFFF, with rst asserted after 10 writes -> all outputs 0 immediately; no done pulse; next accept behaves normally.
- RF_WB_PERF_EN defined, run the scenarios above in order -> perf_lanes = 1+3+1 = 5 before the reset test; perf_results counts each done pulse.

Source files
------------

// File: rtl/rf_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_pkg
// Purpose  : Shared types and default widths for the register-file writeback
//            serializer.
// Revision : 1.0 - initial release
// ============================================================================
package rf_wb_pkg;

    localparam int DEF_NUM_WARPS  = 32;
    localparam int DEF_NUM_LANES  = 32;
    localparam int DEF_VREG_COUNT = 128;
    localparam int DEF_SREG_COUNT = 32;
    localparam int DEF_W          = 32;

    localparam int WARP_W  = 6;
    localparam int LANE_W  = $clog2(DEF_NUM_LANES);
    localparam int VADDR_W = $clog2(DEF_VREG_COUNT);
    localparam int SADDR_W = $clog2(DEF_SREG_COUNT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCALAR = 2'd1,
        DRAIN  = 2'd2
    } wb_state_t;

endpackage : rf_wb_pkg
`default_nettype wire

// File: rtl/rf_wb_lane_pick.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_lane_pick
// Purpose  : Lowest-set-bit priority encoder; returns the lane index, an
//            any-set flag and the mask with that lane cleared.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_lane_pick #(
    parameter  int NUM_LANES = 32,
    localparam int C_LANE_W  = $clog2(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] mask,
    output logic [C_LANE_W-1:0]  lane,
    output logic                 any,
    output logic [NUM_LANES-1:0] mask_clr
);

    // Scan downward so the last hit is the lowest set bit.
    always_comb begin
        lane = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lane = C_LANE_W'(i);
            end
        end
    end

    assign any      = |mask;
    assign mask_clr = mask & (mask - NUM_LANES'(1));

endmodule : rf_wb_lane_pick
`default_nettype wire

// File: rtl/rf_wb_serializer.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_serializer
// Purpose  : Writeback front end: serializes full-warp vector results onto a
//            one-lane-per-cycle write port, routes scalar results, and pulses
//            completion. Optional counters enabled by RF_WB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_serializer
    import rf_wb_pkg::*;
#(
    parameter  int NUM_LANES  = DEF_NUM_LANES,
    parameter  int VREG_COUNT = DEF_VREG_COUNT,
    parameter  int SREG_COUNT = DEF_SREG_COUNT,
    parameter  int W          = DEF_W,
    localparam int C_LANE_W   = $clog2(NUM_LANES),
    localparam int C_VADDR_W  = $clog2(VREG_COUNT),
    localparam int C_SADDR_W  = $clog2(SREG_COUNT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_is_scalar,
    input  logic [WARP_W-1:0]      in_warp,
    input  logic [C_VADDR_W-1:0]   in_addr,
    input  logic [NUM_LANES-1:0]   in_mask,
    input  logic [NUM_LANES*W-1:0] in_data,
    output logic                   s_wen,
    output logic [WARP_W-1:0]      s_wwarp,
    output logic [C_SADDR_W-1:0]   s_waddr,
    output logic [W-1:0]           s_wdata,
    output logic                   v_wen,
    output logic [WARP_W-1:0]      v_wwarp,
    output logic [C_LANE_W-1:0]    v_wlane,
    output logic [C_VADDR_W-1:0]   v_waddr,
    output logic [W-1:0]           v_wdata,
    output logic                   busy,
    output logic                   done_valid,
    output logic [WARP_W-1:0]      done_warp,
    output logic [C_VADDR_W-1:0]   done_addr,
    output logic [31:0]            perf_lanes,
    output logic [31:0]            perf_results
);

    wb_state_t              r_state;
    logic [WARP_W-1:0]      r_warp;
    logic [C_VADDR_W-1:0]   r_addr;
    logic [NUM_LANES-1:0]   r_mask;
    logic [NUM_LANES*W-1:0] r_data;

    logic                   w_accept;
    logic [NUM_LANES-1:0]   w_pick_mask;
    logic [C_LANE_W-1:0]    w_lane;
    logic                   w_any;
    logic [NUM_LANES-1:0]   w_rest;
    logic [W-1:0]           w_lane_data;

    assign in_ready = (r_state == IDLE);
    assign busy     = (r_state != IDLE);
    assign w_accept = in_valid & in_ready;

    // The first lane is picked straight from the input so it is written the
    // cycle after accept; later lanes come from the held mask.
    assign w_pick_mask = (r_state == IDLE) ? in_mask : r_mask;

    rf_wb_lane_pick #(
        .NUM_LANES (NUM_LANES)
    ) u_lane_pick (
        .mask     (w_pick_mask),
        .lane     (w_lane),
        .any      (w_any),
        .mask_clr (w_rest)
    );

    always_comb begin
        w_lane_data = '0;
        if (r_state == IDLE) begin
            w_lane_data = in_data[w_lane*W +: W];
        end else begin
            w_lane_data = r_data[w_lane*W +: W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_warp     <= '0;
            r_addr     <= '0;
            r_mask     <= '0;
            r_data     <= '0;
            s_wen      <= 1'b0;
            s_wwarp    <= '0;
            s_waddr    <= '0;
            s_wdata    <= '0;
            v_wen      <= 1'b0;
            v_wwarp    <= '0;
            v_wlane    <= '0;
            v_waddr    <= '0;
            v_wdata    <= '0;
            done_valid <= 1'b0;
            done_warp  <= '0;
            done_addr  <= '0;
        end else begin
            s_wen      <= 1'b0;
            s_wwarp    <= '0;
            s_waddr    <= '0;
            s_wdata    <= '0;
            v_wen      <= 1'b0;
            v_wwarp    <= '0;
            v_wlane    <= '0;
            v_waddr    <= '0;
            v_wdata    <= '0;
            done_valid <= 1'b0;
            done_warp  <= '0;
            done_addr  <= '0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_warp <= in_warp;
                        r_addr <= in_addr;
                        r_data <= in_data;
                        if (in_is_scalar) begin
                            r_state    <= SCALAR;
                            r_mask     <= '0;
                            s_wen      <= 1'b1;
                            s_wwarp    <= in_warp;
                            s_waddr    <= in_addr[C_SADDR_W-1:0];
                            s_wdata    <= in_data[W-1:0];
                            done_valid <= 1'b1;
                            done_warp  <= in_warp;
                            done_addr  <= in_addr;
                        end else if (w_any) begin
                            r_state <= DRAIN;
                            r_mask  <= w_rest;
                            v_wen   <= 1'b1;
                            v_wwarp <= in_warp;
                            v_wlane <= w_lane;
                            v_waddr <= in_addr;
                            v_wdata <= w_lane_data;
                            if (w_rest == '0) begin
                                done_valid <= 1'b1;
                                done_warp  <= in_warp;
                                done_addr  <= in_addr;
                            end
                        end else begin
                            // Empty vector: completion only, no register write.
                            r_state    <= SCALAR;
                            r_mask     <= '0;
                            done_valid <= 1'b1;
                            done_warp  <= in_warp;
                            done_addr  <= in_addr;
                        end
                    end
                end
                SCALAR: begin
                    r_state <= IDLE;
                end
                DRAIN: begin
                    if (w_any) begin
                        r_mask  <= w_rest;
                        v_wen   <= 1'b1;
                        v_wwarp <= r_warp;
                        v_wlane <= w_lane;
                        v_waddr <= r_addr;
                        v_wdata <= w_lane_data;
                        if (w_rest == '0) begin
                            done_valid <= 1'b1;
                            done_warp  <= r_warp;
                            done_addr  <= r_addr;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef RF_WB_PERF_EN
    logic [31:0] r_perf_lanes;
    logic [31:0] r_perf_results;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_lanes   <= '0;
            r_perf_results <= '0;
        end else begin
            if (v_wen | s_wen) begin
                r_perf_lanes <= r_perf_lanes + 32'd1;
            end
            if (done_valid) begin
                r_perf_results <= r_perf_results + 32'd1;
            end
        end
    end

    assign perf_lanes   = r_perf_lanes;
    assign perf_results = r_perf_results;
`else
    assign perf_lanes   = '0;
    assign perf_results = '0;
`endif

endmodule : rf_wb_serializer
`default_nettype wire

// File: tb/tb_rf_wb_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_serializer
// Purpose  : Scoreboard bench for rf_wb_serializer with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wb_serializer;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_is_scalar;
    logic [5:0]    in_warp;
    logic [6:0]    in_addr;
    logic [31:0]   in_mask;
    logic [1023:0] in_data;
    logic          s_wen;
    logic [5:0]    s_wwarp;
    logic [4:0]    s_waddr;
    logic [31:0]   s_wdata;
    logic          v_wen;
    logic [5:0]    v_wwarp;
    logic [4:0]    v_wlane;
    logic [6:0]    v_waddr;
    logic [31:0]   v_wdata;
    logic          busy;
    logic          done_valid;
    logic [5:0]    done_warp;
    logic [6:0]    done_addr;
    logic [31:0]   perf_lanes;
    logic [31:0]   perf_results;

    always #5 clk = ~clk;

    rf_wb_serializer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_is_scalar (in_is_scalar),
        .in_warp      (in_warp),
        .in_addr      (in_addr),
        .in_mask      (in_mask),
        .in_data      (in_data),
        .s_wen        (s_wen),
        .s_wwarp      (s_wwarp),
        .s_waddr      (s_waddr),
        .s_wdata      (s_wdata),
        .v_wen        (v_wen),
        .v_wwarp      (v_wwarp),
        .v_wlane      (v_wlane),
        .v_waddr      (v_waddr),
        .v_wdata      (v_wdata),
        .busy         (busy),
        .done_valid   (done_valid),
        .done_warp    (done_warp),
        .done_addr    (done_addr),
        .perf_lanes   (perf_lanes),
        .perf_results (perf_results)
    );

    typedef struct packed {
        logic        s_wen;
        logic [5:0]  s_wwarp;
        logic [4:0]  s_waddr;
        logic [31:0] s_wdata;
        logic        v_wen;
        logic [5:0]  v_wwarp;
        logic [4:0]  v_wlane;
        logic [6:0]  v_waddr;
        logic [31:0] v_wdata;
        logic        done_valid;
        logic [5:0]  done_warp;
        logic [6:0]  done_addr;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pops   = 0;

    function automatic obs_t exp_vec(input logic [5:0] w, input logic [4:0] lane,
                                     input logic [6:0] a, input logic [31:0] d,
                                     input logic dn);
        obs_t o;
        o = '0;
        o.v_wen = 1'b1; o.v_wwarp = w; o.v_wlane = lane; o.v_waddr = a; o.v_wdata = d;
        if (dn) begin
            o.done_valid = 1'b1; o.done_warp = w; o.done_addr = a;
        end
        return o;
    endfunction

    function automatic obs_t exp_sca(input logic [5:0] w, input logic [4:0] sa,
                                     input logic [6:0] a, input logic [31:0] d);
        obs_t o;
        o = '0;
        o.s_wen = 1'b1; o.s_wwarp = w; o.s_waddr = sa; o.s_wdata = d;
        o.done_valid = 1'b1; o.done_warp = w; o.done_addr = a;
        return o;
    endfunction

    function automatic obs_t exp_done(input logic [5:0] w, input logic [6:0] a);
        obs_t o;
        o = '0;
        o.done_valid = 1'b1; o.done_warp = w; o.done_addr = a;
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every cycle with any write or done activity consumes one entry.
    always @(negedge clk) begin
        obs_t act;
        obs_t req;
        if (!rst) begin
            act = {s_wen, s_wwarp, s_waddr, s_wdata, v_wen, v_wwarp, v_wlane,
                   v_waddr, v_wdata, done_valid, done_warp, done_addr};
            if (act.s_wen || act.v_wen || act.done_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output actual=%h required=none", act);
                end else begin
                    req = exp_q.pop_front();
                    n_pops++;
                    if (act !== req) begin
                        n_fail++;
                        $display("FAIL write_port actual=%h required=%h", act, req);
                    end
                end
            end
        end
    end

    // Offer one result, then count busy cycles until in_ready returns.
    task automatic send(input string name, input logic sc, input logic [5:0] w,
                        input logic [6:0] a, input logic [31:0] m,
                        input logic [1023:0] d, input int cycles);
        int cnt;
        @(negedge clk);
        chk({name, "_ready_before"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_is_scalar = sc; in_warp = w; in_addr = a;
        in_mask = m; in_data = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) break;
            cnt++;
        end
        chk({name, "_busy_cycles"}, 64'(cnt), 64'(cycles));
        chk({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [1023:0] d;
        int base;
        int waited;

        rst = 1'b1; in_valid = 1'b0; in_is_scalar = 1'b0; in_warp = '0;
        in_addr = '0; in_mask = '0; in_data = '0;
        #1;
        chk("reset_v_wen", 64'(v_wen), 64'd0);
        chk("reset_s_wen", 64'(s_wen), 64'd0);
        chk("reset_done",  64'(done_valid), 64'd0);
        chk("reset_busy",  64'(busy), 64'd0);
        chk("reset_perf",  {perf_lanes, perf_results}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single active lane.
        d = '0; d[31:0] = 32'h1111_0000; d[63:32] = 32'h2222_0000;
        exp_q.push_back(exp_vec(6'd3, 5'd0, 7'h10, 32'h1111_0000, 1'b1));
        send("vec_one_lane", 1'b0, 6'd3, 7'h10, 32'h0000_0001, d, 1);

        // Sparse mask: lanes 0, 2, 31 in ascending order.
        for (int i = 0; i < 32; i++) d[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
        exp_q.push_back(exp_vec(6'd7, 5'd0,  7'h7F, 32'hC0DE_0000, 1'b0));
        exp_q.push_back(exp_vec(6'd7, 5'd2,  7'h7F, 32'hC0DE_0002, 1'b0));
        exp_q.push_back(exp_vec(6'd7, 5'd31, 7'h7F, 32'hC0DE_001F, 1'b1));
        send("vec_sparse", 1'b0, 6'd7, 7'h7F, 32'h8000_0005, d, 3);

        // Scalar: low address bits only, lane-0 data, mask ignored.
        d = '0; d[31:0] = 32'hDEAD_BEEF; d[63:32] = 32'h1234_5678;
        exp_q.push_back(exp_sca(6'd31, 5'h05, 7'h25, 32'hDEAD_BEEF));
        send("scalar", 1'b1, 6'd31, 7'h25, 32'h0000_FFFF, d, 1);

        // Empty vector: done only.
        d = '0; d[31:0] = 32'hFFFF_FFFF;
        exp_q.push_back(exp_done(6'd9, 7'h33));
        send("vec_empty", 1'b0, 6'd9, 7'h33, 32'h0000_0000, d, 1);

`ifdef RF_WB_PERF_EN
        chk("perf_lanes_mid",   64'(perf_lanes),   64'd5);
        chk("perf_results_mid", 64'(perf_results), 64'd4);
`else
        chk("perf_lanes_mid",   64'(perf_lanes),   64'd0);
        chk("perf_results_mid", 64'(perf_results), 64'd0);
`endif

        // Full mask, reset after 10 writes.
        for (int i = 0; i < 32; i++) begin
            d[i*32 +: 32] = 32'h5A00_0000 + 32'(i);
            exp_q.push_back(exp_vec(6'd2, 5'(i), 7'h41, 32'h5A00_0000 + 32'(i), i == 31));
        end
        base = n_pops;
        @(negedge clk);
        in_valid = 1'b1; in_is_scalar = 1'b0; in_warp = 6'd2; in_addr = 7'h41;
        in_mask = 32'hFFFF_FFFF; in_data = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        waited = 0;
        while ((n_pops - base) < 10 && waited < 100) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("rst_writes_before", 64'(n_pops - base), 64'd10);
        rst = 1'b1;
        #1;
        chk("rst_mid_v_wen",  64'(v_wen), 64'd0);
        chk("rst_mid_vdata",  {27'd0, v_wlane, v_wdata}, 64'd0);
        chk("rst_mid_done",   {done_valid, done_warp, done_addr}, 64'd0);
        chk("rst_mid_busy",   64'(busy), 64'd0);
        chk("rst_mid_ready",  64'(in_ready), 64'd1);
        chk("rst_mid_perf",   {perf_lanes, perf_results}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Normal accept after reset; warp beyond NUM_WARPS passes through.
        for (int i = 0; i < 32; i++) d[i*32 +: 32] = 32'h0BAD_0000 + 32'(i);
        exp_q.push_back(exp_vec(6'd40, 5'd1, 7'h02, 32'h0BAD_0001, 1'b0));
        exp_q.push_back(exp_vec(6'd40, 5'd4, 7'h02, 32'h0BAD_0004, 1'b1));
        send("vec_after_rst", 1'b0, 6'd40, 7'h02, 32'h0000_0012, d, 2);

`ifdef RF_WB_PERF_EN
        chk("perf_lanes_end",   64'(perf_lanes),   64'd2);
        chk("perf_results_end", 64'(perf_results), 64'd1);
`else
        chk("perf_lanes_end",   64'(perf_lanes),   64'd0);
        chk("perf_results_end", 64'(perf_results), 64'd0);
`endif

        @(negedge clk);
        @(negedge clk);
        chk("idle_at_end", 64'(busy), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_rf_wb_serializer
`default_nettype wire
